// File: rtl/xadc_sample_reader.sv
// XADC DRP front end: one DRP read per end-of-conversion, offset-binary to signed
// conversion, 2**DECIM_LOG2 averaging, and a small valid/ready output FIFO.
module xadc_sample_reader #(
    parameter logic [6:0] DADDR      = 7'h12,
    parameter int         DECIM_LOG2 = 2,
    parameter int         TIMEOUT    = 31,
    parameter int         FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               eoc,
    input  logic               drdy,
    input  logic [15:0]        do_data,
    output logic               den,
    output logic [6:0]         daddr,
    output logic               dwe,
    input  logic               out_ready,
    output logic [11:0]        sample_out,
    output logic               sample_valid,
    output logic [FIFO_AW:0]   fifo_level,
    input  logic               clear_err,
    output logic               err_timeout,
    output logic               err_overrun
);

    localparam int ACC_W = 12 + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]         TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACC
    } state_t;

    state_t state, state_nx;

    logic                    capture;
    logic                    timeout_hit;
    logic                    acc_en;
    logic [7:0]              tmo_cnt;
    logic signed [11:0]      conv_s;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0]        conv_cnt;
    logic                    last_conv;
    logic                    push;
    logic [11:0]             avg;

    logic [11:0]             mem [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr;
    logic [FIFO_AW-1:0]      rd_ptr;
    logic [FIFO_AW:0]        level;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    // Result sits in do_data[15:4]; the low nibble carries nothing useful.
    logic unused_do_lsb;
    assign unused_do_lsb = ^do_data[3:0];

    assign daddr = DADDR;
    assign dwe   = 1'b0;

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would make results depend on block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nx    = state;
        den         = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        acc_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eoc) state_nx = ST_REQ;
            end
            ST_REQ: begin
                den      = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (drdy) begin
                    capture  = 1'b1;
                    state_nx = ST_ACC;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_IDLE;
                end
            end
            ST_ACC: begin
                acc_en   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Counts WAIT cycles without drdy; zero on WAIT entry so the abort lands
    // exactly TIMEOUT cycles after the den pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT && !drdy && !timeout_hit) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_s <= '0;
        end else if (capture) begin
            conv_s <= {~do_data[15], do_data[14:4]};
        end
    end

    assign acc_sum   = acc + ACC_W'(conv_s);
    assign last_conv = (conv_cnt == CNT_LAST);
    assign push      = acc_en && last_conv;
    assign avg       = 12'(acc_sum >>> DECIM_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            conv_cnt <= '0;
        end else if (acc_en) begin
            if (last_conv) begin
                acc      <= '0;
                conv_cnt <= '0;
            end else begin
                acc      <= acc_sum;
                conv_cnt <= conv_cnt + CNT_ONE;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign full         = (level == LVL_FULL);
    assign sample_valid = (level != '0);
    assign pop          = sample_valid && out_ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign push_ok      = push && (!full || pop);
    assign drop         = push && full && !pop;
    assign sample_out   = mem[rd_ptr];
    assign fifo_level   = level;

    // NOTE: the storage is reset as well, since it is tiny and sample_out reads
    // straight from it and must be zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= avg;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------- sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (timeout_hit)    err_timeout <= 1'b1;
            else if (clear_err) err_timeout <= 1'b0;
            if (drop)           err_overrun <= 1'b1;
            else if (clear_err) err_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xadc_sample_reader.sv
// Randomised bench for xadc_sample_reader against a queue-based model of the
// conversion averaging and output FIFO, plus directed boundary cases.
module tb_xadc_sample_reader;

    localparam int NCONV = 4;   // 2**DECIM_LOG2 for the main instance
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_data = '0;
    logic        out_ready = 1'b0;
    logic        out_ready0 = 1'b0;
    logic        clear_err = 1'b0;

    logic        den, dwe, sample_valid, err_timeout, err_overrun;
    logic [6:0]  daddr;
    logic [11:0] sample_out;
    logic [2:0]  fifo_level;

    logic        den0, dwe0, sample_valid0, err_timeout0, err_overrun0;
    logic [6:0]  daddr0;
    logic [11:0] sample_out0;
    logic [2:0]  fifo_level0;

    xadc_sample_reader #(.DADDR(7'h12), .DECIM_LOG2(2), .TIMEOUT(31), .FIFO_AW(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .eoc(eoc), .drdy(drdy), .do_data(do_data),
        .den(den), .daddr(daddr), .dwe(dwe), .out_ready(out_ready),
        .sample_out(sample_out), .sample_valid(sample_valid), .fifo_level(fifo_level),
        .clear_err(clear_err), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    xadc_sample_reader #(.DADDR(7'h12), .DECIM_LOG2(0), .TIMEOUT(31), .FIFO_AW(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .eoc(eoc), .drdy(drdy), .do_data(do_data),
        .den(den0), .daddr(daddr0), .dwe(dwe0), .out_ready(out_ready0),
        .sample_out(sample_out0), .sample_valid(sample_valid0), .fifo_level(fifo_level0),
        .clear_err(clear_err), .err_timeout(err_timeout0), .err_overrun(err_overrun0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int conv_q[$];
    int exp_q[$];
    bit exp_ovr = 1'b0;
    bit exp_tmo = 1'b0;
    int exp_den = 0;
    int den_count = 0;
    logic pre0, v0;
    logic [11:0] o0;

    always @(negedge clk) begin
        if (!rst_n) den_count = 0;
        else if (den) den_count = den_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model_push(input int s);
        int sum;
        conv_q.push_back(s);
        if (conv_q.size() == NCONV) begin
            sum = 0;
            foreach (conv_q[i]) sum += conv_q[i];
            if (exp_q.size() < DEPTH) exp_q.push_back(floor_div(sum, NCONV) & 'hFFF);
            else exp_ovr = 1'b1;
            conv_q.delete();
        end
    endfunction

    function automatic void reset_model();
        conv_q.delete();
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_tmo = 1'b0;
        exp_den = 0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_valid"}, sample_valid, (exp_q.size() > 0));
        check({tag, "_level"}, fifo_level, exp_q.size());
        if (exp_q.size() > 0) check({tag, "_head"}, sample_out, exp_q[0]);
        check({tag, "_ovr"}, err_overrun, exp_ovr);
        check({tag, "_tmo"}, err_timeout, exp_tmo);
        check({tag, "_dens"}, den_count, exp_den);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; eoc = 1'b0; drdy = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_ovr = 1'b0;
        exp_tmo = 1'b0;
        check("clr_tmo", err_timeout, 0);
        check("clr_ovr", err_overrun, 0);
    endtask

    // One conversion: eoc, wait for den, drdy after `gap` WAIT cycles.
    // Returns at the negedge two cycles after drdy (FSM back in IDLE).
    task automatic do_conv(input logic [15:0] data, input int gap, input bit pop_at_push,
                           input bit noise);
        int waited;
        @(negedge clk);
        drdy = noise;
        do_data = noise ? 16'($urandom) : 16'h0;
        @(negedge clk);
        drdy = 1'b0;
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        waited = 0;
        while (!den && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (!den) begin
            check("den_seen", den, 1);
            return;
        end
        exp_den++;
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            if (i < gap) begin
                eoc = noise & 1'($urandom_range(0, 1));
            end else begin
                eoc = 1'b0;
                drdy = 1'b1;
                do_data = data;
            end
        end
        @(negedge clk);
        drdy = 1'b0;
        pre0 = sample_valid0;
        if (pop_at_push) begin
            out_ready = 1'b1;
            if (exp_q.size() > 0) begin
                check("pop_head", sample_out, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        v0 = sample_valid0;
        o0 = sample_out0;
        model_push(int'(data[15:4]) - 2048);
        check_state("conv");
    endtask

    task automatic drain(input bit rnd);
        int c;
        bit r;
        c = 0;
        while (exp_q.size() > 0 && c < 200) begin
            @(negedge clk);
            c++;
            check("drain_valid", sample_valid, 1);
            check("drain_data", sample_out, exp_q[0]);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0) check("drain_bound", exp_q.size(), 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_empty", sample_valid, 0);
        check("drain_level", fifo_level, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_den", den, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_out", sample_out, 0);
        check("rst_tmo", err_timeout, 0);
        check("rst_ovr", err_overrun, 0);
        check("rst_daddr", daddr, 7'h12);
        check("rst_dwe", dwe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Direct path (DECIM_LOG2=0 instance): drdy 3 cycles after den
        do_conv(16'hFFF0, 3, 1'b0, 1'b0);
        check("d0_lat_pre", pre0, 0);
        check("d0_valid", v0, 1);
        check("d0_data", o0, 12'h7FF);
        repeat (5) @(negedge clk);
        check("d0_den_once", den_count, 1);

        // Averaging of four conversions, including floor rounding and extremes
        apply_reset();
        do_conv(16'h8000, 2, 1'b0, 1'b0);
        do_conv(16'h8010, 1, 1'b0, 1'b0);
        do_conv(16'h8020, 4, 1'b0, 1'b0);
        check("avg_none_yet", sample_valid, 0);
        do_conv(16'h8030, 2, 1'b0, 1'b0);
        check("avg_basic", sample_out, 12'd1);
        do_conv(16'h7FF0, 1, 1'b0, 1'b0);
        repeat (3) do_conv(16'h8000, 1, 1'b0, 1'b0);
        repeat (4) do_conv(16'h0000, 2, 1'b0, 1'b0);
        repeat (4) do_conv(16'hFFFF, 2, 1'b0, 1'b0);
        drain(1'b0);

        // DRP timeout, with clear_err coinciding with the abort
        apply_reset();
        @(negedge clk);
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        check("tmo_den", den, 1);
        exp_den++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            clear_err = (k == 31);
            drdy = (k == 36);
            if (k == 31) check("tmo_early", err_timeout, 0);
            if (k == 32) check("tmo_set", err_timeout, 1);
        end
        drdy = 1'b0;
        clear_err = 1'b0;
        exp_tmo = 1'b1;
        check_state("tmo_idle");
        do_conv(16'($urandom), 2, 1'b0, 1'b0);
        clear_errors();

        // Overrun: five averaged samples with no consumer
        apply_reset();
        for (int j = 0; j < 20; j++) do_conv(16'($urandom), $urandom_range(1, 6), 1'b0, 1'b0);
        check("ovr_level", fifo_level, 4);
        check("ovr_flag", err_overrun, 1);
        drain(1'b0);
        clear_errors();

        // Full FIFO with push and pop in the same cycle
        apply_reset();
        for (int j = 0; j < 19; j++) do_conv(16'($urandom), $urandom_range(1, 4), 1'b0, 1'b0);
        do_conv(16'($urandom), 2, 1'b1, 1'b0);
        check("ppf_level", fifo_level, 4);
        check("ppf_ovr", err_overrun, 0);
        drain(1'b0);

        // Reset while waiting for drdy with two samples queued
        apply_reset();
        for (int j = 0; j < 8; j++) do_conv(16'($urandom), 2, 1'b0, 1'b0);
        check("mid_pre_level", fifo_level, 2);
        @(negedge clk);
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        check("mid_den", den, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_den", den, 0);
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_out", sample_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        for (int j = 0; j < 4; j++) do_conv(16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0);
        check("mid_resume", sample_valid, 1);
        drain(1'b0);

        // Randomised rounds with spurious eoc/drdy and random consumer
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int j = 0; j < n; j++)
                do_conv(16'($urandom), $urandom_range(1, 8), ($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 1)));
            drain(1'b1);
            clear_errors();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
